// File: rtl/conv_channel_accumulator.sv
// conv_channel_accumulator: sums per-pixel partial results over input channels, adds bias,
// saturates (optional ReLU) and streams one output channel image at a time.
module conv_channel_accumulator #(
    parameter int DATA_WIDTH      = 32,
    parameter int IMAGE_WIDTH     = 612,
    parameter int IMAGE_HEIGHT    = 612,
    parameter int CHANNEL_NUM_IN  = 64,
    parameter int CHANNEL_NUM_OUT = 64,
    parameter int RELU_EN         = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    input  logic                  valid_bias_in,
    input  logic [DATA_WIDTH-1:0] bias_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  frame_done,
    output logic                  sat_flag
);
    localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int ACC_WIDTH  = DATA_WIDTH + $clog2(CHANNEL_NUM_IN) + 1;
    localparam int PW = $clog2(IMAGE_SIZE);
    localparam int CW = CHANNEL_NUM_IN > 1 ? $clog2(CHANNEL_NUM_IN) : 1;
    localparam int OW = CHANNEL_NUM_OUT > 1 ? $clog2(CHANNEL_NUM_OUT) : 1;
    localparam logic [PW-1:0] PIX_MAX  = PW'(IMAGE_SIZE - 1);
    localparam logic [CW-1:0] CIN_MAX  = CW'(CHANNEL_NUM_IN - 1);
    localparam logic [OW-1:0] COUT_MAX = OW'(CHANNEL_NUM_OUT - 1);

    logic [PW-1:0]                pix_cnt;
    logic [CW-1:0]                cin_cnt;
    logic [OW-1:0]                cout_cnt;
    logic [DATA_WIDTH-1:0]        bias;
    logic [ACC_WIDTH-1:0]         acc_mem [IMAGE_SIZE];
    logic [ACC_WIDTH-1:0]         base, partial, s1_sum;
    logic [ACC_WIDTH-DATA_WIDTH:0] top;
    logic [DATA_WIDTH-1:0]        clamped, result;
    logic                         pix_last, cin_last, cout_last, s1_valid, s1_frame, ovf;

    always_comb begin
        pix_last  = pix_cnt == PIX_MAX;
        cin_last  = cin_cnt == CIN_MAX;
        cout_last = cout_cnt == COUT_MAX;
        // the first input channel starts fresh, so stale buffer contents are never read
        base      = cin_cnt == '0 ? '0 : acc_mem[pix_cnt];
        partial   = base + {{(ACC_WIDTH-DATA_WIDTH){pxl_in[DATA_WIDTH-1]}}, pxl_in};
        top       = s1_sum[ACC_WIDTH-1:DATA_WIDTH-1];
        ovf       = !(&top || !(|top));
        clamped   = ovf ? {s1_sum[ACC_WIDTH-1], {(DATA_WIDTH-1){~s1_sum[ACC_WIDTH-1]}}}
                        : s1_sum[DATA_WIDTH-1:0];
        result    = (RELU_EN != 0 && clamped[DATA_WIDTH-1]) ? '0 : clamped;
    end

    always_ff @(posedge clk)
        if (valid_in && !cin_last) acc_mem[pix_cnt] <= partial;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pix_cnt    <= '0;
            cin_cnt    <= '0;
            cout_cnt   <= '0;
            bias       <= '0;
            s1_valid   <= 1'b0;
            s1_frame   <= 1'b0;
            s1_sum     <= '0;
            pxl_out    <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            if (valid_in) begin
                pix_cnt <= pix_last ? '0 : pix_cnt + 1'b1;
                if (pix_last) begin
                    cin_cnt <= cin_last ? '0 : cin_cnt + 1'b1;
                    if (cin_last) cout_cnt <= cout_last ? '0 : cout_cnt + 1'b1;
                end
            end
            // the sample accepted this cycle sees the bias held before any simultaneous load
            if (valid_bias_in) bias <= bias_in;
            s1_valid   <= valid_in && cin_last;
            s1_frame   <= valid_in && cin_last && pix_last && cout_last;
            s1_sum     <= partial + {{(ACC_WIDTH-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
            valid_out  <= s1_valid;
            frame_done <= s1_frame;
            if (s1_valid) begin
                pxl_out  <= result;
                sat_flag <= sat_flag | ovf;
            end
        end
    end
endmodule

// File: tb/tb_conv_channel_accumulator.sv
// tb_conv_channel_accumulator: directed checks on a 2x2, 3-in, 2-out build (plain and ReLU)
// plus a single-input-channel build.
module tb_conv_channel_accumulator;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, valid_in = 1'b0, valid_bias_in = 1'b0;
    logic [15:0] pxl_in = '0, bias_in = '0;
    logic [15:0] out0, outr, out1;
    logic v0, vr, fd0, fdr, sat0, satr;
    logic v1_in = 1'b0, vb1 = 1'b0;
    logic [15:0] p1 = '0, b1 = '0;
    logic v1, fd1, sat1;
    int checks = 0, errors = 0;
    int q0[$], qr[$], fdq[$];

    conv_channel_accumulator #(.DATA_WIDTH(16), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2),
        .CHANNEL_NUM_IN(3), .CHANNEL_NUM_OUT(2), .RELU_EN(0)) dut0 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
        .valid_bias_in(valid_bias_in), .bias_in(bias_in), .pxl_out(out0),
        .valid_out(v0), .frame_done(fd0), .sat_flag(sat0));

    conv_channel_accumulator #(.DATA_WIDTH(16), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2),
        .CHANNEL_NUM_IN(3), .CHANNEL_NUM_OUT(2), .RELU_EN(1)) dut_relu (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
        .valid_bias_in(valid_bias_in), .bias_in(bias_in), .pxl_out(outr),
        .valid_out(vr), .frame_done(fdr), .sat_flag(satr));

    conv_channel_accumulator #(.DATA_WIDTH(16), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2),
        .CHANNEL_NUM_IN(1), .CHANNEL_NUM_OUT(2), .RELU_EN(0)) dut_c1 (
        .clk(clk), .reset(reset), .valid_in(v1_in), .pxl_in(p1),
        .valid_bias_in(vb1), .bias_in(b1), .pxl_out(out1),
        .valid_out(v1), .frame_done(fd1), .sat_flag(sat1));

    always @(negedge clk) begin
        if (v0) begin
            q0.push_back(int'($signed(out0)));
            if (fd0) fdq.push_back(q0.size() - 1);
        end else if (fd0) fdq.push_back(-1);
        if (vr) qr.push_back(int'($signed(outr)));
    end

    task automatic step(input logic v, input int p, input logic vb, input int b);
        @(negedge clk);
        valid_in = v;
        pxl_in = 16'(p);
        valid_bias_in = vb;
        bias_in = 16'(b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        valid_in = 1'b0;
        valid_bias_in = 1'b0;
        v1_in = 1'b0;
        vb1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        q0.delete();
        qr.delete();
        fdq.delete();
    endtask

    task automatic run_frame(input int a[2][3], input int b[2], input int pstep, input bit gap);
        for (int co = 0; co < 2; co++) begin
            step(1'b0, 0, 1'b1, b[co]);
            for (int ci = 0; ci < 3; ci++)
                for (int p = 0; p < 4; p++) begin
                    step(1'b1, a[co][ci] + p * pstep, 1'b0, 0);
                    if (gap) idle($urandom_range(0, 2));
                end
        end
        idle(4);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out0 !== 16'd0) begin errors++; $display("FAIL reset_pxl_out: got %0d expected 0", out0); end
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %b expected 0", v0); end
        checks++; if (fd0 !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", fd0); end
        checks++; if (sat0 !== 1'b0) begin errors++; $display("FAIL reset_sat_flag: got %b expected 0", sat0); end
        checks++; if ({outr, vr, fdr, satr, out1, v1, fd1, sat1} !== '0) begin
            errors++; $display("FAIL reset_other_duts: got %h expected 0", {outr, vr, fdr, satr, out1, v1, fd1, sat1});
        end
    endtask

    task automatic test_latency();
        do_reset();
        step(1'b0, 0, 1'b1, 10);
        for (int p = 0; p < 4; p++) step(1'b1, 1, 1'b0, 0);
        for (int p = 0; p < 4; p++) step(1'b1, 2, 1'b0, 0);
        for (int p = 0; p < 4; p++) begin
            step(1'b1, 3, 1'b0, 0);
            idle(1);
            checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL latency_early p%0d: got %b expected 0", p, v0); end
            idle(1);
            checks++; if (v0 !== 1'b1 || out0 !== 16'd16) begin
                errors++; $display("FAIL latency_out p%0d: got v=%b %0d expected v=1 16", p, v0, $signed(out0));
            end
            idle(1);
            checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL latency_late p%0d: got %b expected 0", p, v0); end
        end
    endtask

    task automatic test_basic();
        int a[2][3];
        int b[2];
        int e0[8];
        int er[8];
        a = '{'{1, 2, 3}, '{-1, -1, -1}};
        b = '{10, -5};
        e0 = '{16, 16, 16, 16, -8, -8, -8, -8};
        er = '{16, 16, 16, 16, 0, 0, 0, 0};
        do_reset();
        run_frame(a, b, 0, 1'b0);
        checks++; if (q0.size() != 8 || qr.size() != 8) begin
            errors++; $display("FAIL basic_count: got %0d/%0d expected 8/8", q0.size(), qr.size());
        end
        for (int i = 0; i < 8; i++) begin
            checks++; if (i >= q0.size() || q0[i] != e0[i]) begin
                errors++; $display("FAIL basic_out[%0d]: got %0d expected %0d", i, i < q0.size() ? q0[i] : 0, e0[i]);
            end
            checks++; if (i >= qr.size() || qr[i] != er[i]) begin
                errors++; $display("FAIL basic_relu[%0d]: got %0d expected %0d", i, i < qr.size() ? qr[i] : 0, er[i]);
            end
        end
        checks++; if (sat0 !== 1'b0 || satr !== 1'b0) begin errors++; $display("FAIL basic_sat: got %b%b expected 00", sat0, satr); end
        checks++; if (fdq.size() != 1 || fdq[0] != 7) begin
            errors++; $display("FAIL basic_frame_done: got %0d pulses first %0d expected 1 at 7", fdq.size(), fdq.size() ? fdq[0] : -2);
        end
    endtask

    task automatic test_sat();
        int a[2][3];
        int b[2];
        int e0[8];
        int er[8];
        a = '{'{32767, 32767, 32767}, '{-32768, -32768, -32768}};
        b = '{0, -1};
        e0 = '{32767, 32767, 32767, 32767, -32768, -32768, -32768, -32768};
        er = '{32767, 32767, 32767, 32767, 0, 0, 0, 0};
        do_reset();
        run_frame(a, b, 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++; if (i >= q0.size() || q0[i] != e0[i]) begin
                errors++; $display("FAIL sat_out[%0d]: got %0d expected %0d", i, i < q0.size() ? q0[i] : 0, e0[i]);
            end
            checks++; if (i >= qr.size() || qr[i] != er[i]) begin
                errors++; $display("FAIL sat_relu[%0d]: got %0d expected %0d", i, i < qr.size() ? qr[i] : 0, er[i]);
            end
        end
        checks++; if (sat0 !== 1'b1 || satr !== 1'b1) begin errors++; $display("FAIL sat_flag: got %b%b expected 11", sat0, satr); end
        a = '{'{1, 2, 3}, '{-1, -1, -1}};
        b = '{10, -5};
        q0.delete();
        run_frame(a, b, 0, 1'b0);
        checks++; if (q0.size() < 1 || q0[0] != 16) begin errors++; $display("FAIL sat_after_out: got %0d expected 16", q0.size() ? q0[0] : 0); end
        checks++; if (sat0 !== 1'b1) begin errors++; $display("FAIL sat_sticky: got %b expected 1", sat0); end
    endtask

    task automatic test_gaps();
        int a[2][3];
        int b[2];
        int e0[8];
        int er[8];
        a = '{'{1, 2, 3}, '{-1, -1, -1}};
        b = '{10, -5};
        e0 = '{16, 19, 22, 25, -8, -5, -2, 1};
        er = '{16, 19, 22, 25, 0, 0, 0, 1};
        for (int g = 0; g < 2; g++) begin
            do_reset();
            run_frame(a, b, 1, g[0]);
            checks++; if (q0.size() != 8) begin errors++; $display("FAIL gaps%0d_count: got %0d expected 8", g, q0.size()); end
            for (int i = 0; i < 8; i++) begin
                checks++; if (i >= q0.size() || q0[i] != e0[i] || i >= qr.size() || qr[i] != er[i]) begin
                    errors++; $display("FAIL gaps%0d_out[%0d]: got %0d/%0d expected %0d/%0d", g, i,
                        i < q0.size() ? q0[i] : 0, i < qr.size() ? qr[i] : 0, e0[i], er[i]);
                end
            end
            checks++; if (fdq.size() != 1 || fdq[0] != 7) begin
                errors++; $display("FAIL gaps%0d_frame_done: got %0d pulses expected 1 at 7", g, fdq.size());
            end
        end
    endtask

    task automatic test_back_to_back();
        int a[2][3];
        a = '{'{1, 2, 3}, '{-1, -1, -1}};
        do_reset();
        step(1'b0, 0, 1'b1, 10);
        for (int f = 0; f < 2; f++)
            for (int co = 0; co < 2; co++)
                for (int ci = 0; ci < 3; ci++)
                    for (int p = 0; p < 4; p++)
                        step(1'b1, a[co][ci], ci == 2 && p == 3, co == 0 ? -5 : 10);
        idle(4);
        checks++; if (q0.size() != 16) begin errors++; $display("FAIL b2b_count: got %0d expected 16", q0.size()); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (i >= q0.size() || q0[i] != ((i % 8) < 4 ? 16 : -8)) begin
                errors++; $display("FAIL b2b_out[%0d]: got %0d expected %0d", i, i < q0.size() ? q0[i] : 0, (i % 8) < 4 ? 16 : -8);
            end
        end
        checks++; if (fdq.size() != 2 || fdq[0] != 7 || fdq[1] != 15) begin
            errors++; $display("FAIL b2b_frame_done: got %0d pulses expected 2 at 7,15", fdq.size());
        end
    endtask

    task automatic test_reset_mid();
        int a[2][3];
        int b[2];
        a = '{'{1, 1, 1}, '{1, 1, 1}};
        b = '{1, 1};
        do_reset();
        step(1'b0, 0, 1'b1, 50);
        for (int i = 0; i < 5; i++) step(1'b1, 100, 1'b0, 0);
        do_reset();
        run_frame(a, b, 0, 1'b0);
        checks++; if (q0.size() != 8) begin errors++; $display("FAIL rstmid_count: got %0d expected 8", q0.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (i >= q0.size() || q0[i] != 4) begin
                errors++; $display("FAIL rstmid_out[%0d]: got %0d expected 4", i, i < q0.size() ? q0[i] : 0);
            end
        end
        checks++; if (fdq.size() != 1 || fdq[0] != 7) begin errors++; $display("FAIL rstmid_frame_done: got %0d pulses expected 1", fdq.size()); end
    endtask

    task automatic test_cin1();
        do_reset();
        @(negedge clk);
        vb1 = 1'b1;
        b1 = 16'd2;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vb1 = 1'b0;
            v1_in = 1'b1;
            p1 = 16'd7;
            @(negedge clk);
            v1_in = 1'b0;
            checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL cin1_early[%0d]: got %b expected 0", i, v1); end
            @(negedge clk);
            checks++; if (v1 !== 1'b1 || out1 !== 16'd9) begin
                errors++; $display("FAIL cin1_out[%0d]: got v=%b %0d expected v=1 9", i, v1, out1);
            end
            checks++; if (fd1 !== (i == 7)) begin errors++; $display("FAIL cin1_frame_done[%0d]: got %b expected %b", i, fd1, i == 7); end
        end
        do_reset();
        @(negedge clk);
        v1_in = 1'b1;
        p1 = 16'd7;
        @(negedge clk);
        v1_in = 1'b0;
        @(negedge clk);
        checks++; if (v1 !== 1'b1 || out1 !== 16'd7) begin
            errors++; $display("FAIL cin1_bias_cleared: got v=%b %0d expected v=1 7", v1, out1);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_basic();
        test_sat();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        test_cin1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
